axi4_lite_master_write_engine: RTL and testbench

- Initiator-side AXI4-Lite write engine; drives the AW, W and B handshakes that the slave write interface responds to.
- Accepts one write command at a time from a simple valid/ready command port and issues AW and W together.
- Waits for B, then returns the response on a valid/ready response port.
- Sits between the master agent's request logic and the AXI4-Lite bus; adds a response timeout for hang detection.

---
 rtl/axi4_lite_master_write_engine_pkg.sv | 29 ++
 rtl/axi4_lite_master_write_engine_if.sv | 35 +++
 rtl/axi4_lite_write_timeout_counter.sv | 43 ++++
 rtl/axi4_lite_master_write_engine.sv | 175 +++++++++++++++++
 tb/tb_axi4_lite_master_write_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_master_write_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_write_engine_pkg
// Description : Shared AXI4-Lite response codes, default widths and engine
//               state encoding for the master write engine.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_master_write_engine_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH = 32;
    localparam int c_DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RESP  = 3'd2,
        DONE  = 3'd3,
        FLUSH = 3'd4
    } engine_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_write_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_write_engine_if
// Description : AXI4-Lite write channels (AW, W, B) with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_master_write_engine_if
    import axi4_lite_master_write_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_write_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_write_timeout_counter
// Description : Saturating response-wait counter; expired flags the last
//               permitted cycle. TIMEOUT_CYCLES of 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_write_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(TIMEOUT_CYCLES);

            logic [c_CNT_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_count <= '0;
                end else if (enable && (r_count != c_MAX)) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end

            // Flag the final cycle so the owner leaves after exactly TIMEOUT_CYCLES
            assign expired = enable && (r_count >= c_LAST);
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, enable};
            assign expired  = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/axi4_lite_master_write_engine.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_write_engine
// Description : Single-outstanding AXI4-Lite write initiator with response
//               timeout and post-timeout flush of a late B beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master_write_engine
    import axi4_lite_master_write_engine_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = c_DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic                    aclk,
    input  wire logic                    areset,
    input  wire logic                    cmd_valid,
    output logic                         cmd_ready,
    input  wire logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  wire logic [DATA_WIDTH-1:0]   cmd_data,
    input  wire logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  wire logic [2:0]              cmd_prot,
    output logic                         rsp_valid,
    input  wire logic                    rsp_ready,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,
    output logic                         busy,
    axi4_lite_master_write_engine_if.master axi
);
    engine_state_e           r_state;
    logic                    r_cmd_ready;
    logic                    r_busy;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_bready;
    logic                    r_rsp_valid;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [2:0]              r_prot;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_expired;

    assign w_aw_hs  = r_awvalid && axi.awready;
    assign w_w_hs   = r_wvalid && axi.wready;
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done || w_w_hs;

    // Counter sits at zero outside RESP, so it is clear on every RESP entry
    axi4_lite_write_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (aclk),
        .rst     (areset),
        .clear   (r_state != RESP),
        .enable  (r_state == RESP),
        .expired (w_expired)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= OKAY;
            r_rsp_timeout <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_strb        <= '0;
            r_prot        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_data      <= cmd_data;
                        r_strb      <= cmd_strb;
                        r_prot      <= cmd_prot;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    // A real response takes precedence over a coincident timeout
                    if (axi.bvalid) begin
                        r_rsp_resp    <= axi.bresp;
                        r_rsp_timeout <= 1'b0;
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
                    end else if (w_expired) begin
                        r_rsp_resp    <= SLVERR;
                        r_rsp_timeout <= 1'b1;
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_timeout) begin
                            r_bready <= 1'b1;
                            r_state  <= FLUSH;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // Swallow the B beat of the abandoned write before taking new work
                    if (axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

    assign axi.awvalid = r_awvalid;
    assign axi.awaddr  = r_addr;
    assign axi.awprot  = r_prot;
    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_data;
    assign axi.wstrb   = r_strb;
    assign axi.bready  = r_bready;
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_write_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_master_write_engine
// Description : Directed self-checking bench for the AXI4-Lite write engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master_write_engine;
    localparam int c_AW      = 32;
    localparam int c_DW      = 32;
    localparam int c_TIMEOUT = 8;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [c_AW-1:0]   cmd_addr = '0;
    logic [c_DW-1:0]   cmd_data = '0;
    logic [c_DW/8-1:0] cmd_strb = '0;
    logic [2:0]        cmd_prot = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    axi4_lite_master_write_engine_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) axi ();

    axi4_lite_master_write_engine #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .axi         (axi.master)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_strb  = strb;
        cmd_prot  = prot;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        tick();
        tick();
        areset = 1'b0;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid",   axi.awvalid, 0);
        check("rst_wvalid",    axi.wvalid, 0);
        check("rst_bready",    axi.bready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy",      busy, 0);
        check("rst_rsp_resp",  rsp_resp, 0);
        check("rst_awaddr",    axi.awaddr, 0);

        // 1: all readies high, OKAY
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b00;
        issue(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
        check("t1_awvalid", axi.awvalid, 1);
        check("t1_wvalid",  axi.wvalid, 1);
        check("t1_awaddr",  axi.awaddr, 32'h0000_0010);
        check("t1_wdata",   axi.wdata, 32'hDEAD_BEEF);
        check("t1_wstrb",   axi.wstrb, 4'hF);
        check("t1_awprot",  axi.awprot, 3'd2);
        check("t1_busy",    busy, 1);
        check("t1_cmd_ready", cmd_ready, 0);
        tick();
        check("t1_bready_c2", axi.bready, 1);
        check("t1_awvalid_c2", axi.awvalid, 0);
        check("t1_rsp_valid_c2", rsp_valid, 0);
        tick();
        axi.bvalid = 1'b0;
        check("t1_rsp_valid_c3", rsp_valid, 1);
        check("t1_rsp_resp",   rsp_resp, 2'b00);
        check("t1_rsp_timeout", rsp_timeout, 0);
        check("t1_bready_c3",  axi.bready, 0);
        ack_rsp();
        check("t1_idle_cmd_ready", cmd_ready, 1);
        check("t1_idle_busy", busy, 0);

        // 2: awready delayed, wready immediate
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        issue(32'h0000_0020, 32'h1234_5678, 4'h3, 3'd0);
        check("t2_awvalid_c1", axi.awvalid, 1);
        tick();
        check("t2_wvalid_drop", axi.wvalid, 0);
        check("t2_awvalid_hold", axi.awvalid, 1);
        check("t2_bready_wait", axi.bready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_awvalid_stable", axi.awvalid, 1);
            check("t2_awaddr_stable", axi.awaddr, 32'h0000_0020);
            check("t2_bready_low", axi.bready, 0);
        end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        check("t2_bready_after_aw", axi.bready, 1);
        check("t2_awvalid_done", axi.awvalid, 0);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        tick();
        axi.bvalid = 1'b0;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_resp", rsp_resp, 2'b00);
        ack_rsp();

        // 3: W before AW, SLVERR from slave
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        issue(32'h0000_0100, 32'hCAFE_F00D, 4'hC, 3'd1);
        tick();
        check("t3_wvalid_drop", axi.wvalid, 0);
        axi.awready = 1'b1;
        tick();
        check("t3_bready", axi.bready, 1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_resp", rsp_resp, 2'b10);
        check("t3_rsp_timeout", rsp_timeout, 0);
        ack_rsp();

        // 4: no B beat -> timeout after 8 RESP cycles, then flush
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        issue(32'h0000_0200, 32'h0000_0001, 4'h1, 3'd0);
        tick();
        check("t4_bready", axi.bready, 1);
        for (int i = 0; i < c_TIMEOUT - 1; i++) begin
            tick();
            check("t4_rsp_wait", rsp_valid, 0);
        end
        tick();
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_resp", rsp_resp, 2'b10);
        check("t4_rsp_timeout", rsp_timeout, 1);
        check("t4_bready_done", axi.bready, 0);
        ack_rsp();
        check("t4_flush_bready", axi.bready, 1);
        check("t4_flush_cmd_ready", cmd_ready, 0);
        check("t4_flush_busy", busy, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_flush_hold", cmd_ready, 0);
            check("t4_flush_no_aw", axi.awvalid, 0);
        end
        cmd_valid  = 1'b0;
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
        check("t4_flush_exit_ready", cmd_ready, 1);
        check("t4_flush_exit_bready", axi.bready, 0);
        check("t4_flush_exit_busy", busy, 0);
        check("t4_flush_no_rsp", rsp_valid, 0);

        // 5: reset mid-ADDR
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        issue(32'h0000_0400, 32'h5555_AAAA, 4'hF, 3'd0);
        check("t5_awvalid", axi.awvalid, 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("t5_awvalid", axi.awvalid, 0);
        check("t5_wvalid", axi.wvalid, 0);
        check("t5_bready", axi.bready, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_busy", busy, 0);

        // 6: response back-pressure
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b1;
        axi.bresp   = 2'b01;
        issue(32'h0000_0500, 32'h0BAD_F00D, 4'hF, 3'd0);
        tick();
        tick();
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b11;
        check("t6_rsp_valid", rsp_valid, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0600;
        cmd_data  = 32'h0000_0066;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_rsp_hold", rsp_valid, 1);
            check("t6_resp_hold", rsp_resp, 2'b01);
            check("t6_cmd_blocked", cmd_ready, 0);
            check("t6_no_aw", axi.awvalid, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t6_released", rsp_valid, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t6_next_awvalid", axi.awvalid, 1);
        check("t6_next_awaddr", axi.awaddr, 32'h0000_0600);
        check("t6_next_wdata", axi.wdata, 32'h0000_0066);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
